// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS datapath.
// It decodes the IR opcode, waits on mem_ready in the memory states and counts retired instructions.
module multicycle_control #(
   parameter int CNT_W         = 16,
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       ir_opcode,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic             illegal_op,
   output logic             instr_retired,
   output logic [CNT_W-1:0] retire_count,
   output logic [3:0]       state_dbg
);
   typedef enum logic [3:0] {
      IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMRD = 4'd4,
      MEMWB = 4'd5, MEMWR = 4'd6, EXEC = 4'd7, RWB = 4'd8, BRANCH = 4'd9,
      JUMP = 4'd10, ADDI_EX = 4'd11, ADDI_WB = 4'd12
   } state_t;
   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
   state_t state, nxt;
   logic rdy, legal;
   assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign legal = ir_opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
   assign state_dbg = state;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   // Encodings 13-15 fall through to the default and recover to FETCH.
   always_comb begin
      nxt = FETCH;
      case (state)
         FETCH:   nxt = rdy ? DECODE : FETCH;
         DECODE:  nxt = ir_opcode == OP_R    ? EXEC   :
                        ir_opcode == OP_LW   ? MEMADR :
                        ir_opcode == OP_SW   ? MEMADR :
                        ir_opcode == OP_BEQ  ? BRANCH :
                        ir_opcode == OP_J    ? JUMP   :
                        ir_opcode == OP_ADDI ? ADDI_EX : FETCH;
         MEMADR:  nxt = ir_opcode == OP_LW ? MEMRD : ir_opcode == OP_SW ? MEMWR : FETCH;
         MEMRD:   nxt = rdy ? MEMWB : MEMRD;
         MEMWR:   nxt = rdy ? FETCH : MEMWR;
         EXEC:    nxt = RWB;
         ADDI_EX: nxt = ADDI_WB;
         default: nxt = FETCH;
      endcase
   end
   always_comb begin
      PCWrite       = (state == FETCH && rdy) || state == JUMP;
      PCWriteCond   = state == BRANCH;
      IorD          = state == MEMRD || state == MEMWR;
      MemRead       = state == FETCH || state == MEMRD;
      MemWrite      = state == MEMWR;
      IRWrite       = state == FETCH && rdy;
      MemtoReg      = state == MEMWB;
      RegDst        = state == RWB;
      RegWrite      = state == MEMWB || state == RWB || state == ADDI_WB;
      ALUSrcA       = state == MEMADR || state == EXEC || state == BRANCH || state == ADDI_EX;
      ALUSrcB       = state == FETCH ? 2'b01 : state == DECODE ? 2'b11 :
                      (state == MEMADR || state == ADDI_EX) ? 2'b10 : 2'b00;
      ALUOp         = state == EXEC ? 2'b10 : state == BRANCH ? 2'b01 : 2'b00;
      PCSource      = state == BRANCH ? 2'b01 : state == JUMP ? 2'b10 : 2'b00;
      illegal_op    = state == DECODE && !legal;
      instr_retired = state == MEMWB || state == RWB || state == BRANCH || state == JUMP ||
                      state == ADDI_WB || (state == MEMWR && rdy);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) retire_count <= '0;
      else if (instr_retired) retire_count <= retire_count + 1'b1;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven check of the multicycle control FSM, plus hand-written
// sequences for asynchronous reset, counter wrap and the no-handshake configuration.
module tb_multicycle_control;
   logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b1;
   logic [5:0] op = '0;
   logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill, ret;
   logic [1:0] asb, aop, pcs;
   logic [15:0] cnt;
   logic [3:0] st;
   logic rst1_n = 1'b0, rdy1 = 1'b0;
   logic [5:0] op1 = '0;
   logic pcw1, pcwc1, iord1, mrd1, mwr1, irw1, m2r1, rdst1, rw1, asa1, ill1, ret1;
   logic [1:0] asb1, aop1, pcs1;
   logic [3:0] cnt1, st1;
   logic [17:0] o;
   int passed = 0, total = 0;
   always #5 clk = ~clk;
   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .ir_opcode(op), .mem_ready(rdy),
      .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemRead(mrd), .MemWrite(mwr),
      .IRWrite(irw), .MemtoReg(m2r), .RegDst(rdst), .RegWrite(rw), .ALUSrcA(asa),
      .ALUSrcB(asb), .ALUOp(aop), .PCSource(pcs), .illegal_op(ill), .instr_retired(ret),
      .retire_count(cnt), .state_dbg(st)
   );
   multicycle_control #(.CNT_W(4), .MEM_HANDSHAKE(1'b0)) dut1 (
      .clk(clk), .rst_n(rst1_n), .ir_opcode(op1), .mem_ready(rdy1),
      .PCWrite(pcw1), .PCWriteCond(pcwc1), .IorD(iord1), .MemRead(mrd1), .MemWrite(mwr1),
      .IRWrite(irw1), .MemtoReg(m2r1), .RegDst(rdst1), .RegWrite(rw1), .ALUSrcA(asa1),
      .ALUSrcB(asb1), .ALUOp(aop1), .PCSource(pcs1), .illegal_op(ill1), .instr_retired(ret1),
      .retire_count(cnt1), .state_dbg(st1)
   );
   assign o = {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill, ret};
   localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                          BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, ILL = 6'b111111;
   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,illegal_op,instr_retired}
   localparam logic [17:0]
      O_IDLE = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0,
      O_FR   = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0,
      O_FW   = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0,
      O_DEC  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0,
      O_DILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_0,
      O_MADR = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0,
      O_MRD  = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0,
      O_MWB  = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_1,
      O_MWR0 = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0,
      O_MWR1 = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_1,
      O_EXEC = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0,
      O_RWB  = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_1,
      O_BR   = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_1,
      O_JMP  = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_1,
      O_AWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_1;
   typedef struct {
      logic [5:0]  op;
      logic        rdy;
      logic [3:0]  st;
      logic [17:0] out;
      logic [15:0] cnt;
   } vec_t;
   vec_t tbl[$];
   task automatic add(input logic [5:0] p, input logic r, input logic [3:0] s,
                      input logic [17:0] x, input logic [15:0] c);
      vec_t v;
      v.op = p; v.rdy = r; v.st = s; v.out = x; v.cnt = c;
      tbl.push_back(v);
   endtask
   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
   endtask
   initial begin
      add(R, 1, 0, O_IDLE, 0);
      add(R, 1, 1, O_FR, 0);    add(R, 1, 2, O_DEC, 0);    add(R, 1, 7, O_EXEC, 0);  add(R, 1, 8, O_RWB, 0);
      add(LW, 1, 1, O_FR, 1);   add(LW, 1, 2, O_DEC, 1);   add(LW, 1, 3, O_MADR, 1);
      add(LW, 0, 4, O_MRD, 1);  add(LW, 0, 4, O_MRD, 1);   add(LW, 0, 4, O_MRD, 1);
      add(LW, 1, 4, O_MRD, 1);  add(LW, 1, 5, O_MWB, 1);
      add(ILL, 1, 1, O_FR, 2);  add(ILL, 1, 2, O_DILL, 2);
      add(BEQ, 1, 1, O_FR, 2);  add(BEQ, 1, 2, O_DEC, 2);  add(BEQ, 1, 9, O_BR, 2);
      add(SW, 0, 1, O_FW, 3);   add(SW, 1, 1, O_FR, 3);    add(SW, 1, 2, O_DEC, 3);
      add(SW, 1, 3, O_MADR, 3); add(SW, 0, 6, O_MWR0, 3);  add(SW, 1, 6, O_MWR1, 3);
      add(ADDI, 1, 1, O_FR, 4); add(ADDI, 1, 2, O_DEC, 4); add(ADDI, 1, 11, O_MADR, 4); add(ADDI, 1, 12, O_AWB, 4);
      add(J, 1, 1, O_FR, 5);    add(J, 1, 2, O_DEC, 5);    add(J, 1, 10, O_JMP, 5);
      #1;
      chk("reset_outputs", 0, 32'(o), 32'(O_IDLE));
      chk("reset_count", 0, 32'(cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      foreach (tbl[i]) begin
         if (i > 0) @(negedge clk);
         op = tbl[i].op;
         rdy = tbl[i].rdy;
         #1;
         chk("state", i, 32'(st), 32'(tbl[i].st));
         chk("outputs", i, 32'(o), 32'(tbl[i].out));
         chk("count", i, 32'(cnt), 32'(tbl[i].cnt));
      end
      // Abort an sw mid-MEMWR with an asynchronous reset.
      @(negedge clk); op = SW; rdy = 1'b1; #1;
      chk("t5_fetch", 0, 32'(st), 1);
      chk("t5_count_before", 0, 32'(cnt), 6);
      @(negedge clk); #1 chk("t5_decode", 0, 32'(st), 2);
      @(negedge clk); #1 chk("t5_memadr", 0, 32'(st), 3);
      @(negedge clk); rdy = 1'b0; #1;
      chk("t5_memwr", 0, 32'(st), 6);
      chk("t5_memwrite_hi", 0, 32'(mwr), 1);
      rst_n = 1'b0; #1;
      chk("t5_memwrite_lo", 0, 32'(mwr), 0);
      chk("t5_state_idle", 0, 32'(st), 0);
      chk("t5_count_zero", 0, 32'(cnt), 0);
      chk("t5_outputs_zero", 0, 32'(o), 32'(O_IDLE));
      @(negedge clk); rst_n = 1'b1; rdy = 1'b1; #1;
      chk("t5_release_idle", 0, 32'(st), 0);
      @(negedge clk); #1;
      chk("t5_then_fetch", 0, 32'(st), 1);
      chk("t5_count_after", 0, 32'(cnt), 0);
      // No-handshake instance: FETCH completes with mem_ready low; 17 jumps wrap a 4-bit count.
      @(negedge clk); rst1_n = 1'b1; op1 = J; rdy1 = 1'b0; #1;
      chk("t6_idle", 0, 32'(st1), 0);
      @(negedge clk); #1;
      chk("t6_fetch", 0, 32'(st1), 1);
      chk("t6_fetch_pcwrite", 0, 32'(pcw1), 1);
      chk("t6_fetch_irwrite", 0, 32'(irw1), 1);
      @(negedge clk); #1;
      chk("t6_decode", 0, 32'(st1), 2);
      @(negedge clk); #1;
      chk("t6_jump_retire", 0, 32'(ret1), 1);
      repeat (46) @(negedge clk);
      #1 chk("t6_count_16_wrap", 0, 32'(cnt1), 0);
      chk("t6_fetch17", 0, 32'(st1), 1);
      repeat (3) @(negedge clk);
      #1 chk("t6_count_17", 0, 32'(cnt1), 1);
      chk("t6_fetch18", 0, 32'(st1), 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
